// File: rtl/strobe_bank.sv
// Multi-channel level-to-strobe converter: synchroniser, stability filter,
// edge-mode event detect, retriggerable pulse stretcher, sticky flag and saturating counter.
module strobe_bank #(
    parameter int unsigned         CHANNELS    = 4,
    parameter int unsigned         SYNC_STAGES = 2,
    parameter int unsigned         FILTER_W    = 4,
    parameter int unsigned         PULSE_W     = 4,
    parameter int unsigned         CNT_W       = 8,
    parameter logic [CHANNELS-1:0] INIT_LEVEL  = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       in,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [FILTER_W-1:0]       filter_len,
    input  logic [PULSE_W-1:0]        pulse_len,
    input  logic [CHANNELS-1:0]       sticky_clr,
    output logic [CHANNELS-1:0]       out,
    output logic [CHANNELS-1:0]       level,
    output logic [CHANNELS-1:0]       sticky,
    output logic [CHANNELS*CNT_W-1:0] count
);

    // Terminal values L-1 and P-1, with a programmed 0 behaving as 1.
    logic [FILTER_W-1:0] filt_top;
    logic [PULSE_W-1:0]  pulse_top;

    always_comb begin
        filt_top  = (filter_len == '0) ? '0 : FILTER_W'(filter_len - 1'b1);
        pulse_top = (pulse_len == '0)  ? '0 : PULSE_W'(pulse_len - 1'b1);
    end

    for (genvar ch = 0; ch < int'(CHANNELS); ch++) begin : g_ch
        logic                s;
        logic                f;
        logic [FILTER_W-1:0] c;
        logic [PULSE_W-1:0]  p;
        logic                o;
        logic                stk;
        logic [CNT_W-1:0]    cnt;
        logic                differ;
        logic                upd;
        logic                ev;

        if (SYNC_STAGES == 0) begin : g_bypass
            assign s = in[ch];
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_q <= {SYNC_STAGES{INIT_LEVEL[ch]}};
                end else begin
                    sync_q[0] <= in[ch];
                    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end

        // A run already at or past a shortened L updates on the next differing cycle.
        always_comb begin
            differ = s ^ f;
            upd    = differ && (c >= filt_top);
            ev     = (mode[2*ch] & upd & s) | (mode[2*ch+1] & upd & ~s);
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                f   <= INIT_LEVEL[ch];
                c   <= '0;
                p   <= '0;
                o   <= 1'b0;
                stk <= 1'b0;
                cnt <= '0;
            end else begin
                if (!differ) begin
                    c <= '0;
                end else if (upd) begin
                    f <= s;
                    c <= '0;
                end else begin
                    c <= FILTER_W'(c + 1'b1);
                end

                if (ev) begin
                    p <= pulse_top;
                    o <= 1'b1;
                end else if (p != '0) begin
                    p <= PULSE_W'(p - 1'b1);
                end else begin
                    o <= 1'b0;
                end

                // Set wins over a simultaneous clear.
                if (ev) begin
                    stk <= 1'b1;
                end else if (sticky_clr[ch]) begin
                    stk <= 1'b0;
                end

                if (ev && (cnt != '1)) begin
                    cnt <= CNT_W'(cnt + 1'b1);
                end
            end
        end

        assign out[ch]                   = o;
        assign level[ch]                 = f;
        assign sticky[ch]                = stk;
        assign count[CNT_W*ch +: CNT_W]  = cnt;
    end

endmodule

// File: tb/tb_strobe_bank.sv
// Scoreboard bench for strobe_bank: stimulus queues cycle-tagged expectations,
// a negedge monitor retires and compares them.
module tb_strobe_bank;

    localparam int unsigned CH    = 4;
    localparam int unsigned CNT_W = 3;

    typedef struct {
        int cyc;
        int kind;
        int ch;
        int val;
    } chk_t;

    logic              clk;
    logic              reset_n;
    logic [CH-1:0]     din;
    logic [2*CH-1:0]   mode;
    logic [3:0]        filter_len;
    logic [3:0]        pulse_len;
    logic [CH-1:0]     sticky_clr;
    logic [CH-1:0]     dout;
    logic [CH-1:0]     level;
    logic [CH-1:0]     sticky;
    logic [CH*CNT_W-1:0] count;

    chk_t  q[$];
    int    edge_n = 0;
    int    total  = 0;
    int    bad    = 0;
    logic [CH-1:0] init_lv = 4'b0010;
    string kname [4] = '{"out", "level", "sticky", "count"};

    strobe_bank #(
        .CHANNELS   (CH),
        .SYNC_STAGES(2),
        .FILTER_W   (4),
        .PULSE_W    (4),
        .CNT_W      (CNT_W),
        .INIT_LEVEL (4'b0010)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in        (din),
        .mode      (mode),
        .filter_len(filter_len),
        .pulse_len (pulse_len),
        .sticky_clr(sticky_clr),
        .out       (dout),
        .level     (level),
        .sticky    (sticky),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic int actual(int kind, int ch);
        case (kind)
            0:       return int'(dout[ch]);
            1:       return int'(level[ch]);
            2:       return int'(sticky[ch]);
            default: return int'(count[ch*CNT_W +: CNT_W]);
        endcase
    endfunction

    task automatic cmp(string nm, int ch, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s ch%0d cyc=%0d got=%0d exp=%0d", nm, ch, edge_n, act, exp);
        end
    endtask

    task automatic push(int cyc, int kind, int ch, int val);
        chk_t e;
        e.cyc = cyc; e.kind = kind; e.ch = ch; e.val = val;
        q.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Retire every expectation due on the edge just taken.
    always @(negedge clk) begin : monitor
        int idx;
        idx = 0;
        while (idx < q.size()) begin
            if (q[idx].cyc < edge_n) begin
                total++;
                bad++;
                $display("FAIL late_%s ch%0d due=%0d now=%0d", kname[q[idx].kind], q[idx].ch, q[idx].cyc, edge_n);
                q.delete(idx);
            end else if (q[idx].cyc == edge_n) begin
                cmp(kname[q[idx].kind], q[idx].ch, actual(q[idx].kind, q[idx].ch), q[idx].val);
                q.delete(idx);
            end else begin
                idx++;
            end
        end
    end

    initial begin : stim
        int t0;
        int t1;
        int e;
        int d;
        int r;
        logic w;

        reset_n    = 1'b0;
        din        = 4'b0010;
        mode       = 8'hFF;
        filter_len = 4'd1;
        pulse_len  = 4'd3;
        sticky_clr = '0;

        for (int ch = 0; ch < 4; ch++) begin
            push(1, 0, ch, 0);
            push(1, 1, ch, int'(init_lv[ch]));
            push(1, 2, ch, 0);
            push(1, 3, ch, 0);
        end
        step(3);
        reset_n = 1'b1;

        // Inputs equal to INIT_LEVEL: quiet outputs, level holds init value.
        t0 = edge_n;
        for (int n = 1; n <= 20; n++)
            for (int ch = 0; ch < 4; ch++) push(t0 + n, 0, ch, 0);
        for (int ch = 0; ch < 4; ch++) begin
            push(t0 + 20, 1, ch, int'(init_lv[ch]));
            push(t0 + 20, 3, ch, 0);
        end
        step(20);

        // Latency and pulse width: ch0 rising, L=1, P=3.
        mode = 8'b00_00_00_01;
        t0 = edge_n;
        e  = t0 + 3;
        push(e - 1, 0, 0, 0);
        push(e - 1, 1, 0, 0);
        push(e - 1, 2, 0, 0);
        push(e,     0, 0, 1);
        push(e,     1, 0, 1);
        push(e,     2, 0, 1);
        push(e,     3, 0, 1);
        push(e + 1, 0, 0, 1);
        push(e + 2, 0, 0, 1);
        push(e + 3, 0, 0, 0);
        din[0] = 1'b1;
        step(8);

        // Glitch filter on ch1 (falling mode, starts high): 3-cycle dip rejected.
        mode       = 8'b00_00_10_01;
        filter_len = 4'd4;
        t0 = edge_n;
        for (int n = 1; n <= 10; n++) begin
            push(t0 + n, 0, 1, 0);
            push(t0 + n, 1, 1, 1);
        end
        push(t0 + 10, 3, 1, 0);
        din[1] = 1'b0;
        step(3);
        din[1] = 1'b1;
        step(7);

        // Held low long enough: level falls on edge 2+L.
        t1 = edge_n;
        e  = t1 + 6;
        push(e - 1, 0, 1, 0);
        push(e - 1, 1, 1, 1);
        push(e,     0, 1, 1);
        push(e,     1, 1, 0);
        push(e,     3, 1, 1);
        push(e + 1, 0, 1, 1);
        push(e + 2, 0, 1, 1);
        push(e + 3, 0, 1, 0);
        din[1] = 1'b0;
        step(10);

        // Modes: ch0 off, ch2 falling, ch3 both; period-16 square wave, L=1, P=1.
        mode       = 8'b11_10_00_00;
        filter_len = 4'd1;
        pulse_len  = 4'd1;
        t0 = edge_n;
        for (int n = 1; n <= 56; n++) begin
            d = n - 3;
            push(t0 + n, 0, 0, 0);
            push(t0 + n, 0, 2, int'(d >= 0 && d <= 40 && (d % 16) == 8));
            push(t0 + n, 0, 3, int'(d >= 0 && d <= 40 && (d % 8) == 0));
        end
        push(t0 + 56, 3, 0, 1);
        push(t0 + 56, 3, 2, 3);
        push(t0 + 56, 3, 3, 6);
        for (int i = 0; i < 56; i++) begin
            w = (i < 48) && ((i % 16) < 8);
            din[0] = w;
            din[2] = w;
            din[3] = w;
            step(1);
        end

        // Retrigger with P=8 and sticky set/clear priority on ch0.
        mode      = 8'b00_00_00_01;
        pulse_len = 4'd8;
        t0 = edge_n;
        for (int n = 1; n <= 22; n++)
            push(t0 + n, 0, 0, int'(n >= 3 && n <= 18));
        push(t0 + 7,  2, 0, 1);
        push(t0 + 12, 3, 0, 4);
        push(t0 + 13, 2, 0, 1);
        push(t0 + 14, 2, 0, 0);
        for (int i = 0; i < 22; i++) begin
            din[0]        = (i < 12) && ((i % 4) < 2);
            sticky_clr[0] = (i == 6) || (i == 13);
            step(1);
        end

        // Counter saturation at 7, then asynchronous reset mid-pulse.
        t0 = edge_n;
        push(t0 + 4,  3, 0, 5);
        push(t0 + 8,  3, 0, 6);
        push(t0 + 12, 3, 0, 7);
        push(t0 + 24, 3, 0, 7);
        push(t0 + 24, 0, 0, 1);
        for (int ch = 0; ch < 4; ch++) begin
            push(t0 + 25, 0, ch, 0);
            push(t0 + 25, 1, ch, int'(init_lv[ch]));
            push(t0 + 25, 2, ch, 0);
            push(t0 + 25, 3, ch, 0);
        end
        for (int i = 0; i < 25; i++) begin
            din[0] = (i < 24) && ((i % 4) < 2);
            step(1);
        end
        #1;
        reset_n = 1'b0;
        #1;
        cmp("async_out", 0, int'(dout), 0);
        cmp("async_count", 0, int'(count), 0);

        // Released with ch1 input differing from its init level: one falling event.
        mode       = 8'b00_00_10_00;
        pulse_len  = 4'd2;
        filter_len = 4'd1;
        step(2);
        reset_n = 1'b1;
        r = edge_n;
        push(r + 2, 0, 1, 0);
        push(r + 2, 1, 1, 1);
        push(r + 3, 0, 1, 1);
        push(r + 3, 1, 1, 0);
        push(r + 3, 3, 1, 1);
        push(r + 4, 0, 1, 1);
        push(r + 5, 0, 1, 0);
        step(10);

        while (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL pending_%s ch%0d due=%0d", kname[q[0].kind], q[0].ch, q[0].cyc);
            void'(q.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
